// File: rtl/key_pulse_gen.sv
// Push-button conditioner: per-key two-flop synchroniser, debounce FSM and
// counter, and a serialiser that emits one single-cycle pulse per confirmed press.
module key_pulse_gen #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] key_level,
  output logic                any_held
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  // A wait state is left on the cycle its counter would step to DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  state_t              state_q [NUM_KEYS];
  state_t              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] req_q, req_d;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [NUM_KEYS-1:0] pulse_q, pulse_d;
  logic [NUM_KEYS-1:0] pend_all;
  logic [NUM_KEYS-1:0] grant;
  logic                found;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      case (state_q[i])
        IDLE: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            req_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        HELD: begin
          if (sync2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Lowest-index request wins; a request for an already pending key merges into it.
  always_comb begin
    pend_all = pending_q | req_q;
    grant    = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pend_all[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    pending_d = pend_all & ~grant;
    pulse_d   = grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      req_q     <= '0;
      pending_q <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    key_level = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_level[i] = (state_q[i] == HELD) || (state_q[i] == RELEASE_WAIT);
    end
  end

  assign press_pulse = pulse_q;
  assign any_held    = |key_level;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen with a short debounce (D = 4); expected
// pulses are queued with their cycle number and matched as the DUT emits them.
module tb_key_pulse_gen;

  localparam int NK = 3;
  localparam int D  = 4;

  logic          clk;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] key_level;
  logic          any_held;

  typedef struct {
    int            cyc;
    logic [NK-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  key_pulse_gen #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .press_pulse (press_pulse),
    .key_level   (key_level),
    .any_held    (any_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Called just after a falling edge; the next rising edge samples the new value.
  task automatic applyStimulus(input logic [NK-1:0] kn);
    key_n = kn;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expectPulse(input int at_cyc, input logic [NK-1:0] val);
    exp_t e;
    e.cyc = at_cyc;
    e.val = val;
    sb.push_back(e);
  endtask

  // Every nonzero pulse must match the head of the scoreboard, value and cycle.
  always @(negedge clk) begin
    if (press_pulse !== '0) begin
      checkOutput("pulse_onehot", 32'($onehot0(press_pulse)), 32'd1);
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", 32'(press_pulse), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("pulse_val", 32'(press_pulse), 32'(e.val));
        checkOutput("pulse_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  int e0;
  int f0;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    key_n  = '1;
    tick(3);
    checkOutput("rst_pulse", 32'(press_pulse), 32'd0);
    checkOutput("rst_level", 32'(key_level), 32'd0);
    checkOutput("rst_any", 32'(any_held), 32'd0);
    rst = 1'b0;

    // Idle: nothing may move with all keys released
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i % 5 == 4) checkOutput("idle_level", 32'(key_level), 32'd0);
    end
    checkOutput("idle_any", 32'(any_held), 32'd0);

    // Clean press of key 0 held for 30 cycles
    e0 = cyc + 1;
    expectPulse(e0 + 6, 3'b001);
    applyStimulus(3'b110);
    tick(e0 + 4 - cyc);
    checkOutput("k0_level_early", 32'(key_level[0]), 32'd0);
    tick(1);
    checkOutput("k0_level_rise", 32'(key_level[0]), 32'd1);
    checkOutput("k0_any", 32'(any_held), 32'd1);
    tick(25);
    checkOutput("k0_level_held", 32'(key_level), 32'b001);
    applyStimulus(3'b111);
    tick(D + 1);
    checkOutput("k0_level_rel_wait", 32'(key_level[0]), 32'd1);
    tick(1);
    checkOutput("k0_level_fall", 32'(key_level[0]), 32'd0);
    tick(4);

    // Bounce on key 1: never stable long enough
    applyStimulus(3'b101); tick(3);
    applyStimulus(3'b111); tick(2);
    applyStimulus(3'b101); tick(2);
    applyStimulus(3'b111);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checkOutput("bounce_level", 32'(key_level[1]), 32'd0);
    end
    e0 = cyc + 1;
    expectPulse(e0 + 6, 3'b010);
    applyStimulus(3'b101);
    tick(10);
    checkOutput("k1_level_held", 32'(key_level[1]), 32'd1);
    applyStimulus(3'b111);
    tick(12);
    checkOutput("k1_level_rel", 32'(key_level), 32'd0);

    // Simultaneous press of keys 0 and 2
    e0 = cyc + 1;
    expectPulse(e0 + 6, 3'b001);
    expectPulse(e0 + 7, 3'b100);
    applyStimulus(3'b010);
    tick(15);
    checkOutput("k02_level", 32'(key_level), 32'b101);
    applyStimulus(3'b111);
    tick(12);

    // Release glitch on key 0, then a clean release and a second press
    e0 = cyc + 1;
    expectPulse(e0 + 6, 3'b001);
    applyStimulus(3'b110);
    tick(12);
    applyStimulus(3'b111); tick(2);
    applyStimulus(3'b110);
    for (int i = 0; i < 8; i++) begin
      checkOutput("glitch_level", 32'(key_level[0]), 32'd1);
      tick(1);
    end
    applyStimulus(3'b111);
    tick(10);
    checkOutput("glitch_rel_level", 32'(key_level[0]), 32'd0);
    e0 = cyc + 1;
    expectPulse(e0 + 6, 3'b001);
    applyStimulus(3'b110);
    tick(10);
    applyStimulus(3'b111);
    tick(12);

    // Reset during the press debounce of key 2, key kept held
    e0 = cyc + 1;
    applyStimulus(3'b011);
    tick(e0 + 3 - cyc);
    rst = 1'b1;
    tick(2);
    checkOutput("mid_rst_pulse", 32'(press_pulse), 32'd0);
    checkOutput("mid_rst_level", 32'(key_level), 32'd0);
    f0 = cyc + 1;
    expectPulse(f0 + 6, 3'b100);
    rst = 1'b0;
    tick(f0 + 4 - cyc);
    checkOutput("post_rst_level_early", 32'(key_level[2]), 32'd0);
    tick(1);
    checkOutput("post_rst_level", 32'(key_level[2]), 32'd1);
    tick(8);
    applyStimulus(3'b111);
    tick(12);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
